// File: rtl/word_mem_access_unit_if.sv
// Request/response channel between the core model and the word memory access unit.
interface word_mem_access_unit_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/word_mem_access_unit.sv
// Word load/store front end over a byte-wide memory: each word access is split
// into four sequential single-byte accesses and answered on a response channel.
module word_mem_access_unit #(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned MEM_BYTES = 512,
    parameter int unsigned IDX_W     = 9
) (
    input logic                    clock,
    input logic                    reset,
    word_mem_access_unit_if.slave  bus
);
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    // Byte storage is deliberately outside reset so contents survive it.
    logic [7:0]          mem [MEM_BYTES];

    logic [IDX_W-1:0]    req_base_c;
    logic                in_range_c;
    logic [IDX_W-1:0]    byte_idx_c;
    logic [7:0]          rd_byte_c;
    logic                mem_we_c;
    logic [7:0]          mem_wbyte_c;

    assign req_base_c = IDX_W'({bus.req_addr, 2'b00});
    assign in_range_c = (bus.req_addr[ADDR_W-1:IDX_W-2] == '0);
    assign byte_idx_c = base_q + IDX_W'(cnt_q);
    assign rd_byte_c  = mem[byte_idx_c];

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        asm_d        = asm_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_we_c     = 1'b0;
        mem_wbyte_c  = wdata_q[{cnt_q, 3'b000} +: 8];

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    base_d  = req_base_c;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    asm_d   = '0;
                    cnt_d   = '0;
                    if (in_range_c) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end

            S_ACCESS: begin
                // Masked store bytes still take their cycle to keep latency fixed.
                if (write_q) begin
                    mem_we_c = wstrb_q[cnt_q];
                end else begin
                    asm_d[{cnt_q, 3'b000} +: 8] = rd_byte_c;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = write_q ? '0 : asm_d;
                end
            end

            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // Control and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            base_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            asm_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            asm_q        <= asm_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // A byte write already in flight completes even in a reset cycle.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[byte_idx_c] <= mem_wbyte_c;
        end
    end
endmodule

// File: tb/tb_word_mem_access_unit.sv
// Bench for word_mem_access_unit: table of word transactions checked through a
// response scoreboard, plus hand-written reset and memory-content sequences.
module tb_word_mem_access_unit;
    logic clock;
    logic reset;

    word_mem_access_unit_if #(.ADDR_W(30)) bus ();

    word_mem_access_unit #(
        .ADDR_W   (30),
        .MEM_BYTES(512),
        .IDX_W    (9)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        write;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic transact(input vec_t v);
        int          n;
        int          lat;
        vec_t        e;
        logic [31:0] first_rdata;
        exp_q.push_back(v);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_write = v.write;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_wstrb = v.wstrb;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!bus.resp_valid && lat < 20);
        e = exp_q.pop_front();
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(e.exp_lat));
        chk("resp_rdata", bus.resp_rdata, e.exp_rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e.exp_err));
        first_rdata = bus.resp_rdata;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rdata", bus.resp_rdata, first_rdata);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1 bus.resp_ready = 1'b0;
        @(negedge clock);
        chk("post_hs_valid", 32'(bus.resp_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.req_ready), 32'd1);
    endtask

    function automatic vec_t mk(input logic w, input logic [29:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, input logic [31:0] er, input logic ee,
                                input int lat, input int hold);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.wstrb = ws;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.hold = hold;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(1'b1, 30'd5,   32'hDEADBEEF, 4'hF,    32'h0,        1'b0, 5, 0));
        vecs.push_back(mk(1'b0, 30'd5,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 5, 0));
        vecs.push_back(mk(1'b1, 30'd5,   32'h11223344, 4'b0101, 32'h0,        1'b0, 5, 0));
        vecs.push_back(mk(1'b0, 30'd5,   32'h0,        4'h0,    32'hDE22BE44, 1'b0, 5, 0));
        vecs.push_back(mk(1'b1, 30'd127, 32'hA5A50F0F, 4'hF,    32'h0,        1'b0, 5, 0));
        vecs.push_back(mk(1'b0, 30'd127, 32'h0,        4'h0,    32'hA5A50F0F, 1'b0, 5, 6));
        vecs.push_back(mk(1'b1, 30'd0,   32'h00000000, 4'hF,    32'h0,        1'b0, 5, 0));
        vecs.push_back(mk(1'b0, 30'd128, 32'h0,        4'h0,    32'h0,        1'b1, 1, 0));
        vecs.push_back(mk(1'b1, 30'd128, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1, 1, 2));
        vecs.push_back(mk(1'b0, 30'h2000_0005, 32'h0,  4'h0,    32'h0,        1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 30'd0,   32'h0,        4'h0,    32'h00000000, 1'b0, 5, 0));
        vecs.push_back(mk(1'b0, 30'd127, 32'h0,        4'h0,    32'hA5A50F0F, 1'b0, 5, 0));
        vecs.push_back(mk(1'b0, 30'd127, 32'h0,        4'h0,    32'hA5A50F0F, 1'b0, 5, 0));
        vecs.push_back(mk(1'b1, 30'd3,   32'h00000000, 4'hF,    32'h0,        1'b0, 5, 0));

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);

        foreach (vecs[i]) transact(vecs[i]);

        // Byte layout of the little-endian words written above.
        chk("mem20", 32'(dut.mem[20]), 32'h44);
        chk("mem21", 32'(dut.mem[21]), 32'hBE);
        chk("mem22", 32'(dut.mem[22]), 32'h22);
        chk("mem23", 32'(dut.mem[23]), 32'hDE);
        chk("mem508", 32'(dut.mem[508]), 32'h0F);
        chk("mem511", 32'(dut.mem[511]), 32'hA5);
        chk("mem0_untouched", 32'(dut.mem[0]), 32'h00);

        // Reset lands during the second byte cycle of a store: bytes 0 and 1 persist.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 30'd3;
        bus.req_wdata = 32'hFFFFFFFF;
        bus.req_wstrb = 4'hF;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        transact(mk(1'b0, 30'd3, 32'h0, 4'h0, 32'h0000FFFF, 1'b0, 5, 0));

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/word_mem_access_unit.md
Name: word_mem_access_unit

Overview:
- Word-level front end for the 512-byte core-side byte memory used in the RISC-V ILA verification lemmas.
- Takes 32-bit word load/store requests from the core model over a valid/ready channel.
- Converts each word address to a byte base address ({addr,2'b00}) and performs four sequential single-byte accesses, one per cycle.
- Returns the assembled little-endian word, or a store acknowledge, on a valid/ready response channel.

Parameters:
- ADDR_W, 30, width of word address.
- MEM_BYTES, 512, byte storage depth; must be a power of two and a multiple of 4.
- IDX_W, 9, log2(MEM_BYTES); byte index width.

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1=store, 0=load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  32  store data, byte0 = bits[7:0].
- req_wstrb  input  4  per-byte store enable.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  address out of range.

Behaviour:
- Storage: MEM_BYTES x 8 array. Contents are not reset; they hold across reset. One byte read or write per cycle.
- Byte base = ({req_addr,2'b00})[IDX_W-1:0]; bytes base+0..base+3 map to data bits [7:0],[15:8],[23:16],[31:24].
- Range check: request is in range iff req_addr[ADDR_W-1:IDX_W-2] == 0.
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state=IDLE, byte counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
- IDLE:
  - req_ready=1.
  - On req_valid: latch write, addr, wdata, wstrb and clear the assembly register.
  - If in range, go to ACCESS with cnt=0.
  - If out of range, go to RESP with resp_err=1 and resp_rdata=0; memory is untouched.
- ACCESS:
  - req_ready=0; one byte per cycle at index base+cnt.
  - Load: assembly byte[cnt] <= mem[base+cnt].
  - Store: mem[base+cnt] <= wdata byte[cnt] only if wstrb[cnt]=1. A masked byte still consumes its cycle, so latency is fixed.
  - cnt increments 0->3; after the cnt=3 cycle go to RESP.
- RESP:
  - resp_valid=1.
  - resp_rdata = assembled word for loads, 0 for stores.
  - Outputs stay stable while resp_ready=0.
  - On resp_ready, go to IDLE and clear resp_valid.
  - No request is accepted in the same cycle as the response handshake.
- Latency: request accepted at edge T; the byte accesses occupy cycles T+1..T+4; resp_valid is high from T+5. An out-of-range request responds at T+1.
- Cross-byte ordering: a load issued after a store to the same word returns the stored bytes, because the store completes before its response.
- No wrap-around: the base is 4-aligned, so base+3 never exceeds MEM_BYTES-1.
- Reset mid-operation: the FSM returns to IDLE next cycle and any pending response is dropped. Bytes already written by a partial store remain in memory.
- req_valid while not IDLE is ignored; the requester must hold it until req_ready.

Test Plan:
- Store addr=5, wdata=32'hDEADBEEF, wstrb=4'hF, then load addr=5 -> resp_rdata=32'hDEADBEEF; mem[20..23]=EF,BE,AD,DE; resp_valid first high 5 cycles after each accept.
- Store addr=5, wdata=32'h11223344, wstrb=4'b0101, then load addr=5 -> 32'hDE22BE44.
- Load addr=127 (bytes 508..511) after a full store of 32'hA5A5_0F0F -> 32'hA5A50F0F; addr=128 -> resp_err=1, rdata=0 at T+1, memory unchanged.
- Response backpressure: hold resp_ready=0 for 6 cycles -> resp_valid and resp_rdata stable; req_ready=0 throughout; handshake returns the unit to IDLE next cycle.
- Assert reset at cycle T+2 of a store of 32'hFFFFFFFF to addr=3 over prior 32'h0 -> next cycle IDLE, resp_valid=0; load addr=3 returns 32'h0000FFFF (bytes 0,1 written).
- Two words with equal addr[6:0] loaded back-to-back -> identical data, matching the byte-memory lemma.
